// File: rtl/atm_pin_entry.sv
// ATM keypad front end. It collects a 2-bit PIN and then a 2-bit amount from
// keypad strobes, counts wrong PIN attempts up to a lockout, and aborts the
// session when no key arrives for too long. Removing the card always returns
// the block to IDLE and clears everything that was committed.
module atm_pin_entry #(
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IC,
  input  logic [1:0] pin,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] entered_pin,
  output logic [1:0] ammount_entered,
  output logic       pin_valid,
  output logic       amt_valid,
  output logic       wrong_pin,
  output logic       locked,
  output logic       timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PIN_WAIT = 3'd1;
  localparam logic [2:0] S_AMT_WAIT = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_LOCKED   = 3'd4;
  localparam logic [2:0] S_EJECT    = 3'd5;

  logic [2:0]       state;
  logic [1:0]       pin_buf;
  logic             buf_full;
  logic [TRY_W-1:0] tries;
  logic [CNT_W-1:0] idle_cnt;

  logic             in_entry;
  logic             is_digit;
  logic             is_clear;
  logic             is_enter;
  logic             idle_expire;
  logic [TRY_W-1:0] tries_inc;

  // Key decode, idle expiry detection and the saturating try increment.
  always_comb begin
    in_entry    = (state == S_PIN_WAIT) || (state == S_AMT_WAIT);
    is_digit    = key_valid && (key_code[3:2] == 2'b00);
    is_clear    = key_valid && (key_code == 4'hA);
    is_enter    = key_valid && (key_code == 4'hB) && buf_full;
    idle_expire = in_entry && !key_valid && (idle_cnt == CNT_LAST);
    tries_inc   = (tries >= TRY_MAX) ? TRY_MAX : tries + TRY_W'(1);
  end

  // Session state machine with all outputs registered; card removal has
  // priority over any key or timeout seen in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      pin_buf         <= '0;
      buf_full        <= 1'b0;
      tries           <= '0;
      idle_cnt        <= '0;
      entered_pin     <= '0;
      ammount_entered <= '0;
      pin_valid       <= 1'b0;
      amt_valid       <= 1'b0;
      wrong_pin       <= 1'b0;
      locked          <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      wrong_pin <= 1'b0;
      timeout   <= 1'b0;
      if ((state != S_IDLE) && !IC) begin
        state           <= S_IDLE;
        buf_full        <= 1'b0;
        tries           <= '0;
        idle_cnt        <= '0;
        entered_pin     <= '0;
        ammount_entered <= '0;
        pin_valid       <= 1'b0;
        amt_valid       <= 1'b0;
        locked          <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            idle_cnt <= '0;
            if (IC) state <= S_PIN_WAIT;
          end
          S_PIN_WAIT, S_AMT_WAIT: begin
            // Any strobe, even an unrecognised code, counts as activity.
            if (key_valid) idle_cnt <= '0;
            else           idle_cnt <= idle_cnt + CNT_W'(1);
            if (is_digit) begin
              pin_buf  <= key_code[1:0];
              buf_full <= 1'b1;
            end else if (is_clear) begin
              buf_full <= 1'b0;
            end else if (is_enter) begin
              buf_full <= 1'b0;
              if (state == S_AMT_WAIT) begin
                ammount_entered <= pin_buf;
                amt_valid       <= 1'b1;
                state           <= S_DONE;
              end else if (pin_buf == pin) begin
                entered_pin <= pin_buf;
                pin_valid   <= 1'b1;
                tries       <= '0;
                state       <= S_AMT_WAIT;
              end else begin
                wrong_pin <= 1'b1;
                tries     <= tries_inc;
                if (tries_inc == TRY_MAX) begin
                  locked <= 1'b1;
                  state  <= S_LOCKED;
                end
              end
            end else if (idle_expire) begin
              timeout   <= 1'b1;
              buf_full  <= 1'b0;
              pin_valid <= 1'b0;
              amt_valid <= 1'b0;
              idle_cnt  <= '0;
              state     <= S_EJECT;
            end
          end
          S_DONE, S_LOCKED, S_EJECT: begin
            idle_cnt <= '0;
          end
          default: begin
            idle_cnt <= '0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
